// File: rtl/chad_cop_pkg.sv
// Shared encodings for the chad multiply/divide coprocessor.
// Command selects, FSM states and result-mux selects live here.
package chad_cop_pkg;

   localparam logic [2:0] COP_SEL_LO   = 3'd0;
   localparam logic [2:0] COP_MUL      = 3'd1;
   localparam logic [2:0] COP_DIV      = 3'd2;
   localparam logic [2:0] COP_SEL_HI   = 3'd3;
   localparam logic [2:0] COP_SEL_STAT = 3'd4;

   typedef enum logic {
      ST_IDLE,
      ST_RUN
   } state_t;

   typedef enum logic [1:0] {
      RSEL_LO,
      RSEL_HI,
      RSEL_STAT
   } rsel_t;

endpackage

// File: rtl/chad_coproc.sv
// Iterative unsigned multiply / restoring divide coprocessor for the chad core.
// One result bit per cycle through a single shared WIDTH+1-bit adder/subtractor.
import chad_cop_pkg::*;

module chad_coproc #(
   parameter int WIDTH = 18
) (
   input  logic             clk,
   input  logic             resetq,
   input  logic             hold_in,
   input  logic             copgo,
   input  logic [10:0]      sel,
   input  logic [WIDTH-1:0] copa,
   input  logic [WIDTH-1:0] copb,
   input  logic [WIDTH-1:0] copc,
   output logic [WIDTH-1:0] cop,
   output logic             stall
);

   localparam int CW = $clog2(WIDTH) + 1;

   state_t           state_reg, state_next;
   rsel_t            rsel_reg;
   logic [WIDTH-1:0] lo_reg, hi_reg, b_reg;
   logic [CW-1:0]    count_reg;
   logic             ovf_reg, op_div_reg, skip_reg;

   logic             busy, accept, cmd_valid, start_op;
   logic [WIDTH:0]   add_a, add_b;
   logic             add_cin;
   logic [WIDTH+1:0] sum;

   assign busy      = (state_reg != ST_IDLE);
   assign stall     = copgo & busy;
   assign accept    = copgo & ~hold_in & ~busy;
   assign cmd_valid = accept & (sel[10:3] == 8'd0);
   assign start_op  = cmd_valid & ((sel[2:0] == COP_MUL) | (sel[2:0] == COP_DIV));

   always_ff @(posedge clk or negedge resetq) begin
      if (!resetq) state_reg <= ST_IDLE;
      else         state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: if (start_op) state_next = ST_RUN;
         ST_RUN:  if (count_reg == '0) state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   // MUL adds the multiplicand when lo[0] is set; DIV subtracts the divisor
   // from the left-shifted partial remainder {hi, lo msb}.
   always_comb begin
      add_a   = {1'b0, hi_reg};
      add_b   = '0;
      add_cin = 1'b0;
      if (op_div_reg) begin
         add_a   = {hi_reg, lo_reg[WIDTH-1]};
         add_b   = ~{1'b0, b_reg};
         add_cin = 1'b1;
      end else if (lo_reg[0]) begin
         add_b = {1'b0, b_reg};
      end
   end

   assign sum = {1'b0, add_a} + {1'b0, add_b} + {{(WIDTH+1){1'b0}}, add_cin};

   always_ff @(posedge clk or negedge resetq) begin
      if (!resetq) begin
         lo_reg     <= '0;
         hi_reg     <= '0;
         b_reg      <= '0;
         ovf_reg    <= 1'b0;
         count_reg  <= '0;
         rsel_reg   <= RSEL_LO;
         op_div_reg <= 1'b0;
         skip_reg   <= 1'b0;
      end else if (cmd_valid) begin
         case (sel[2:0])
            COP_SEL_LO:   rsel_reg <= RSEL_LO;
            COP_SEL_HI:   rsel_reg <= RSEL_HI;
            COP_SEL_STAT: rsel_reg <= RSEL_STAT;
            COP_MUL: begin
               hi_reg     <= '0;
               lo_reg     <= copa;
               b_reg      <= copb;
               ovf_reg    <= 1'b0;
               count_reg  <= CW'(WIDTH - 1);
               op_div_reg <= 1'b0;
               skip_reg   <= 1'b0;
            end
            COP_DIV: begin
               op_div_reg <= 1'b1;
               if (copc >= copb) begin
                  // Quotient would not fit (or divide by zero): flag and finish in one cycle.
                  ovf_reg   <= 1'b1;
                  lo_reg    <= '1;
                  hi_reg    <= copc;
                  count_reg <= '0;
                  skip_reg  <= 1'b1;
               end else begin
                  ovf_reg   <= 1'b0;
                  hi_reg    <= copc;
                  lo_reg    <= copa;
                  b_reg     <= copb;
                  count_reg <= CW'(WIDTH - 1);
                  skip_reg  <= 1'b0;
               end
            end
            default: ;
         endcase
      end else if (state_reg == ST_RUN) begin
         if (!skip_reg) begin
            if (op_div_reg) begin
               if (sum[WIDTH+1]) begin
                  hi_reg <= sum[WIDTH-1:0];
                  lo_reg <= {lo_reg[WIDTH-2:0], 1'b1};
               end else begin
                  hi_reg <= add_a[WIDTH-1:0];
                  lo_reg <= {lo_reg[WIDTH-2:0], 1'b0};
               end
            end else begin
               hi_reg <= sum[WIDTH:1];
               lo_reg <= {sum[0], lo_reg[WIDTH-1:1]};
            end
         end
         if (count_reg != '0) count_reg <= count_reg - 1'b1;
      end
   end

   always_comb begin
      cop = '0;
      case (rsel_reg)
         RSEL_LO:   cop = lo_reg;
         RSEL_HI:   cop = hi_reg;
         RSEL_STAT: cop = {{(WIDTH-2){1'b0}}, ovf_reg, busy};
         default:   cop = '0;
      endcase
   end

endmodule
